// File: rtl/controller_sequencer.sv
// SAP-1 control unit: a one-hot T1..T6 ring plus HALT, decoding the IR opcode
// into the load/send/count strobes for every datapath register.
module controller_sequencer #(
  parameter logic [3:0] HLT_OPCODE = 4'b1111
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_enable,
  input  logic       i_debug,
  input  logic [3:0] i_opcode,
  output logic [5:0] o_t_state,
  output logic       o_halted,
  output logic       o_pc_increment,
  output logic       o_pc_send,
  output logic       o_mar_load,
  output logic       o_ram_send,
  output logic       o_ir_load,
  output logic       o_ir_send_address,
  output logic       o_a_load,
  output logic       o_a_send,
  output logic       o_b_load,
  output logic       o_alu_send,
  output logic       o_alu_subtract,
  output logic       o_out_load
);

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;

  typedef enum logic [6:0] {
    T1   = 7'b0000001,
    T2   = 7'b0000010,
    T3   = 7'b0000100,
    T4   = 7'b0001000,
    T5   = 7'b0010000,
    T6   = 7'b0100000,
    HALT = 7'b1000000
  } state_t;

  state_t state, state_next;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values; the async reset sits in the sensitivity list.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= T1;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (i_enable) begin
      case (state)
        T1:      state_next = T2;
        T2:      state_next = T3;
        T3:      state_next = T4;
        T4:      state_next = (i_opcode == HLT_OPCODE) ? HALT : T5;
        T5:      state_next = T6;
        T6:      state_next = T1;
        HALT:    state_next = HALT;
        default: state_next = T1;
      endcase
    end
  end

  // Tracing is done by the simulation environment; i_debug has no hardware effect.
  assign o_halted  = (state == HALT) & (i_debug | 1'b1);
  assign o_t_state = state[5:0];

  // NOTE: every strobe gets a default before the case so no latch is inferred.
  always_comb begin
    o_pc_increment    = 1'b0;
    o_pc_send         = 1'b0;
    o_mar_load        = 1'b0;
    o_ram_send        = 1'b0;
    o_ir_load         = 1'b0;
    o_ir_send_address = 1'b0;
    o_a_load          = 1'b0;
    o_a_send          = 1'b0;
    o_b_load          = 1'b0;
    o_alu_send        = 1'b0;
    o_alu_subtract    = 1'b0;
    o_out_load        = 1'b0;
    // Strobes are suppressed while reset is held even though the state reads T1.
    if (i_reset_n && i_opcode != HLT_OPCODE) begin
      case (state)
        T1: begin o_pc_send = 1'b1; o_mar_load = 1'b1; end
        T2: o_pc_increment = 1'b1;
        T3: begin o_ram_send = 1'b1; o_ir_load = 1'b1; end
        T4: begin
          if (i_opcode == OP_LDA || i_opcode == OP_ADD || i_opcode == OP_SUB) begin
            o_ir_send_address = 1'b1;
            o_mar_load        = 1'b1;
          end else if (i_opcode == OP_OUT) begin
            o_a_send   = 1'b1;
            o_out_load = 1'b1;
          end
        end
        T5: begin
          if (i_opcode == OP_LDA) begin
            o_ram_send = 1'b1;
            o_a_load   = 1'b1;
          end else if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
            o_ram_send = 1'b1;
            o_b_load   = 1'b1;
          end
        end
        T6: begin
          if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
            o_alu_send     = 1'b1;
            o_a_load       = 1'b1;
            o_alu_subtract = (i_opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end else if (i_reset_n) begin
      // A HLT opcode only matters from T4; fetch strobes are opcode independent.
      case (state)
        T1: begin o_pc_send = 1'b1; o_mar_load = 1'b1; end
        T2: o_pc_increment = 1'b1;
        T3: begin o_ram_send = 1'b1; o_ir_load = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controller_sequencer.sv
// Scoreboard bench for controller_sequencer: the driver queues the expected
// output word for each cycle, a negedge monitor pops and compares it.
module tb_controller_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       debug = 1'b0;
  logic [3:0] opcode = 4'b0000;
  logic [5:0] t_state;
  logic       halted, pc_increment, pc_send, mar_load, ram_send, ir_load;
  logic       ir_send_address, a_load, a_send, b_load, alu_send, alu_subtract, out_load;

  controller_sequencer dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(enable), .i_debug(debug),
    .i_opcode(opcode), .o_t_state(t_state), .o_halted(halted),
    .o_pc_increment(pc_increment), .o_pc_send(pc_send), .o_mar_load(mar_load),
    .o_ram_send(ram_send), .o_ir_load(ir_load), .o_ir_send_address(ir_send_address),
    .o_a_load(a_load), .o_a_send(a_send), .o_b_load(b_load), .o_alu_send(alu_send),
    .o_alu_subtract(alu_subtract), .o_out_load(out_load)
  );

  always #5 clk = ~clk;

  // Strobe word bit positions, msb first.
  localparam logic [11:0] PC_INC   = 12'h800;
  localparam logic [11:0] PC_SEND  = 12'h400;
  localparam logic [11:0] MAR_LOAD = 12'h200;
  localparam logic [11:0] RAM_SEND = 12'h100;
  localparam logic [11:0] IR_LOAD  = 12'h080;
  localparam logic [11:0] IR_SEND  = 12'h040;
  localparam logic [11:0] A_LOAD   = 12'h020;
  localparam logic [11:0] A_SEND   = 12'h010;
  localparam logic [11:0] B_LOAD   = 12'h008;
  localparam logic [11:0] ALU_SEND = 12'h004;
  localparam logic [11:0] ALU_SUB  = 12'h002;
  localparam logic [11:0] OUT_LOAD = 12'h001;
  localparam logic [11:0] NONE     = 12'h000;

  logic [18:0] dut_word;
  assign dut_word = {t_state, halted, pc_increment, pc_send, mar_load, ram_send, ir_load,
                     ir_send_address, a_load, a_send, b_load, alu_send, alu_subtract, out_load};

  typedef struct {
    logic [18:0] word;
    string       name;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  // t = 1..6 selects that T-state; t = 0 means HALT.
  function automatic logic [18:0] w(input int t, input logic [11:0] s);
    logic [5:0] ts;
    if (t == 0) return {6'b000000, 1'b1, s};
    ts = 6'b000001 << (t - 1);
    return {ts, 1'b0, s};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [4:0] drivers;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      compared++;
      if (dut_word !== e.word) begin
        mismatched++;
        $display("FAIL %s: got %b required %b", e.name, dut_word, e.word);
      end
    end
    drivers = {pc_send, ram_send, ir_send_address, a_send, alu_send};
    compared++;
    if ($countones(drivers) > 1) begin
      mismatched++;
      $display("FAIL single_driver: got drivers %b required at most one set", drivers);
    end
    compared++;
    if (alu_subtract && !alu_send) begin
      mismatched++;
      $display("FAIL sub_without_send: got alu_subtract=1 alu_send=0 required alu_send=1");
    end
  end

  task automatic step(input logic en, input logic [3:0] op, input logic [18:0] exp_word,
                      input string name);
    exp_t e;
    enable = en;
    opcode = op;
    e.word = exp_word;
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle(input string name);
    exp_t e;
    rst_n  = 1'b0;
    enable = 1'b1;
    e.word = w(1, NONE);
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic fetch(input string tag);
    step(1'b1, 4'($urandom), w(1, PC_SEND | MAR_LOAD), {tag, "_t1"});
    step(1'b1, 4'($urandom), w(2, PC_INC),             {tag, "_t2"});
    step(1'b1, 4'($urandom), w(3, RAM_SEND | IR_LOAD), {tag, "_t3"});
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [11:0] e4, input logic [11:0] e5,
                           input logic [11:0] e6, input string tag);
    fetch(tag);
    step(1'b1, op, w(4, e4), {tag, "_t4"});
    step(1'b1, op, w(5, e5), {tag, "_t5"});
    step(1'b1, op, w(6, e6), {tag, "_t6"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk);
    #1;
    // Reset held: T1 visible, strobes forced off.
    step(1'b1, 4'b0000, w(1, NONE), "reset_held");
    rst_n = 1'b1;

    run_instr(4'b0000, IR_SEND | MAR_LOAD, RAM_SEND | A_LOAD, NONE, "lda");
    run_instr(4'b0010, IR_SEND | MAR_LOAD, RAM_SEND | B_LOAD, ALU_SEND | A_LOAD | ALU_SUB, "sub");
    run_instr(4'b0001, IR_SEND | MAR_LOAD, RAM_SEND | B_LOAD, ALU_SEND | A_LOAD, "add");
    run_instr(4'b1110, A_SEND | OUT_LOAD, NONE, NONE, "out");
    run_instr(4'b0111, NONE, NONE, NONE, "nop");

    // Enable pattern 1,0,0,1,0,1 from T1.
    step(1'b1, 4'($urandom), w(1, PC_SEND | MAR_LOAD), "en_t1");
    step(1'b0, 4'($urandom), w(2, PC_INC),             "en_t2a");
    step(1'b0, 4'($urandom), w(2, PC_INC),             "en_t2b");
    step(1'b1, 4'($urandom), w(2, PC_INC),             "en_t2c");
    step(1'b0, 4'($urandom), w(3, RAM_SEND | IR_LOAD), "en_t3a");
    step(1'b1, 4'($urandom), w(3, RAM_SEND | IR_LOAD), "en_t3b");
    step(1'b1, 4'b0000, w(4, IR_SEND | MAR_LOAD),      "en_t4");
    step(1'b1, 4'b0000, w(5, RAM_SEND | A_LOAD),       "en_t5");
    step(1'b1, 4'b0000, w(6, NONE),                    "en_t6");

    // HLT: halt after T4, stays halted regardless of enable, reset recovers.
    fetch("hlt");
    step(1'b1, 4'b1111, w(4, NONE), "hlt_t4");
    for (int i = 0; i < 20; i++)
      step(1'($urandom), 4'($urandom), w(0, NONE), "halted");
    reset_cycle("reset_in_halt");
    run_instr(4'b0000, IR_SEND | MAR_LOAD, RAM_SEND | A_LOAD, NONE, "post_halt");

    // Asynchronous reset asserted mid-T5.
    fetch("mid");
    step(1'b1, 4'b0001, w(4, IR_SEND | MAR_LOAD), "mid_t4");
    reset_cycle("reset_mid_t5");
    run_instr(4'b0001, IR_SEND | MAR_LOAD, RAM_SEND | B_LOAD, ALU_SEND | A_LOAD, "post_mid");

    // Random opcodes and enables: invariants are checked every cycle.
    for (int i = 0; i < 1000; i++) begin
      if (i % 64 == 63) rst_n = 1'b0;
      enable = ($urandom_range(0, 3) != 0);
      opcode = 4'($urandom);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
    end

    @(negedge clk);
    #1;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/controller_sequencer.md
# controller_sequencer

SAP-1 control unit. A six-state one-hot ring counter (T1–T6) steps each enabled clock. It decodes the 4-bit opcode held in the instruction register into active-high load/send/count strobes for the program counter, MAR, RAM, instruction register, A/B registers, ALU and output register. It sits between the instruction register's opcode output and every datapath register's control inputs, and it stops the machine on HLT.

## Interface
- `HLT_OPCODE`, default 4'b1111: opcode that halts the sequencer.
- `i_clock`  in  1  system clock; all state changes on the rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_enable`  in  1  clock enable; the ring advances only when this is 1 (single-step/run control).
- `i_debug`  in  1  simulation-only; when 1, print the state and control word on each advance.
- `i_opcode`  in  4  opcode from the instruction register; sampled only in T4–T6.
- `o_t_state`  out  6  one-hot current T-state, bit0 = T1; 6'b000000 when halted.
- `o_halted`  out  1  1 while in HALT.
- `o_pc_increment`, `o_pc_send`  out  1 each  program counter count / drive bus.
- `o_mar_load`  out  1  MAR load from bus.
- `o_ram_send`  out  1  RAM drives bus.
- `o_ir_load`, `o_ir_send_address`  out  1 each  IR load / IR address nibble to bus.
- `o_a_load`, `o_a_send`  out  1 each  accumulator load / drive bus.
- `o_b_load`  out  1  B register load.
- `o_alu_send`, `o_alu_subtract`  out  1 each  ALU drives bus / select subtract.
- `o_out_load`  out  1  output register load.

## Operation
- States: T1..T6, HALT. The state is a one-hot register. The controls are decoded combinationally from the state and `i_opcode`.
- Fetch, independent of opcode:
  - T1: `pc_send`, `mar_load`.
  - T2: `pc_increment`.
  - T3: `ram_send`, `ir_load`.
- Execute:
  - LDA 4'b0000:
    - T4: `ir_send_address`, `mar_load`.
    - T5: `ram_send`, `a_load`.
    - T6: none.
  - ADD 4'b0001:
    - T4: `ir_send_address`, `mar_load`.
    - T5: `ram_send`, `b_load`.
    - T6: `alu_send`, `a_load`.
  - SUB 4'b0010: same as ADD, plus `alu_subtract` in T6.
  - OUT 4'b1110:
    - T4: `a_send`, `out_load`.
    - T5, T6: none.
  - HLT_OPCODE: T4 has no strobes; it is followed by HALT.
  - Any other opcode: NOP; no strobes in T4–T6.
- Transitions, when `i_enable`=1:
  - Tn advances to Tn+1.
  - T6 advances to T1.
  - T4 goes to HALT when `i_opcode`==HLT_OPCODE.
  - When `i_enable`=0, the state holds and the strobes stay as decoded for the held state.
- HALT:
  - All strobes are 0, `o_halted`=1 and `o_t_state`=0.
  - HALT is exited only by reset; `i_enable` is ignored.
- Invariant: at most one of `pc_send`, `ram_send`, `ir_send_address`, `a_send`, `alu_send` is 1 in any cycle (single bus driver).
- `alu_subtract` is never 1 unless `alu_send` is 1.

## Timing
- Reset (`i_reset_n`=0, asynchronous):
  - State goes to T1 immediately.
  - While reset is held, all strobes are forced to 0, `o_halted`=0 and `o_t_state`=6'b000001.
  - After release, T1 strobes appear in the same cycle.
  - The first advance is at the first rising edge with `i_enable`=1.
- Strobe semantics:
  - A strobe asserted during state Tn is consumed by the target register at the rising edge that ends Tn.
  - `ir_load` in T3 makes the new opcode valid from T4 onward.
- Latency:
  - A full instruction takes 6 enabled cycles.
  - HLT reaches HALT after 4 enabled cycles from T1.
- Opcode changes during T1–T3 must have no effect on the outputs.
- Reset mid-instruction: the state returns to T1 asynchronously, with no partial-strobe completion requirement.
- Reset while HALT: return to T1.
- `i_enable` toggling mid-instruction:
  - No states are skipped or duplicated.
  - Each enabled edge advances exactly one state.

## Test plan
- Reset then `i_enable`=1, opcode 4'b0000 (LDA), 6 clocks -> `o_t_state` goes 000001, 000010, 000100, 001000, 010000, 100000, then 000001. Strobes per state:
  - T1: `pc_send`+`mar_load`
  - T2: `pc_increment`
  - T3: `ram_send`+`ir_load`
  - T4: `ir_send_address`+`mar_load`
  - T5: `ram_send`+`a_load`
  - T6: none
- Opcode 4'b0010 (SUB) through T6 -> `alu_send`=`a_load`=`alu_subtract`=1 in T6. Opcode 4'b0001 (ADD) -> same, but `alu_subtract`=0.
- Opcode 4'b1111 -> after the T4 edge, `o_halted`=1, `o_t_state`=0 and all strobes 0 for 20 further clocks. Then pulse `i_reset_n` low -> `o_t_state`=000001.
- `i_enable` pattern 1,0,0,1,0,1 from T1 -> the state sequence reads T1, T2, T2, T2, T3, T3, T4 at successive edges, with strobes stable while held.
- Assert `i_reset_n`=0 asynchronously mid-T5 (between edges) -> `o_t_state`=000001 and all strobes 0 without waiting for a clock edge.
- Random opcodes for 1000 cycles -> the single-driver invariant always holds. Opcode flips during T1–T3 cause no output change.
